bldc_drive_sequencer: RTL and testbench

Supervisory controller for the Hall-driven six-step commutation stage. It owns the commutator's `forward` input and a global gate enable. It sequences start, stop and direction reversal so the bridge never reverses while the rotor is still spinning, and inserts a dwell interval before gates re-enable. It also measures the Hall edge period and latches a fault on persistent invalid Hall codes.

---
 rtl/bldc_pkg.sv | 29 ++
 rtl/bldc_drive_sequencer_hall_edge_timer.sv | 76 +++++++
 rtl/bldc_drive_sequencer.sv | 168 ++++++++++++++++
 tb/tb_bldc_drive_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/bldc_pkg.sv
// Shared definitions for the BLDC drive sequencer: FSM state codes,
// invalid Hall code values and default timing constants.
package bldc_pkg;

    // Supervisory FSM states; the numeric codes appear on the debug state port
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DWELL = 3'd1,
        ST_RUN   = 3'd2,
        ST_COAST = 3'd3,
        ST_FAULT = 3'd4
    } seq_state_e;

    // Hall codes that cannot occur on a healthy sensor set
    localparam logic [2:0] HALL_INVALID_LO = 3'b000;
    localparam logic [2:0] HALL_INVALID_HI = 3'b111;

    // Default timing for a production build
    localparam int DEF_CNT_W          = 24;
    localparam int DEF_STALL_CYCLES   = 2000000;
    localparam int DEF_DWELL_CYCLES   = 50000;
    localparam int DEF_INVALID_CYCLES = 1000;

    // True for the all-low / all-high Hall patterns
    function automatic logic hall_code_invalid(input logic [2:0] code);
        return (code == HALL_INVALID_LO) || (code == HALL_INVALID_HI);
    endfunction

endpackage

// File: rtl/bldc_drive_sequencer_hall_edge_timer.sv
// Hall front end: synchronizes the three raw Hall inputs, detects any
// change of the synced code, measures the clocks between changes and
// flags a stalled rotor when no change has been seen for STALL_CYCLES.
module hall_edge_timer
    import bldc_pkg::*;
#(
    parameter int CNT_W        = DEF_CNT_W,
    parameter int STALL_CYCLES = DEF_STALL_CYCLES
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_halla,
    input  logic             i_hallb,
    input  logic             i_hallc,
    output logic [2:0]       o_hall_code,
    output logic             o_stalled,
    output logic [CNT_W-1:0] o_hall_period
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] STALL_TH = CNT_W'(STALL_CYCLES);

    logic [2:0]       w_hall_raw;
    logic [2:0]       r_hall_meta;
    logic [2:0]       r_hall_sync;
    logic [2:0]       r_hall_prev;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] w_stall_cnt_next;
    logic             w_edge;
    logic             r_stalled;
    logic [CNT_W-1:0] r_hall_period;

    assign w_hall_raw = {i_halla, i_hallb, i_hallc};

    // Edge detect and saturating clocks-since-last-edge counter
    always_comb begin
        w_edge = (r_hall_sync != r_hall_prev);
        if (w_edge) begin
            w_stall_cnt_next = '0;
        end else if (r_stall_cnt == CNT_MAX) begin
            w_stall_cnt_next = r_stall_cnt;
        end else begin
            w_stall_cnt_next = r_stall_cnt + CNT_W'(1);
        end
    end

    // Synchronizer, previous-code copy, stall flag and period capture
    always_ff @(posedge clock) begin
        if (reset) begin
            r_hall_meta   <= '0;
            r_hall_sync   <= '0;
            r_hall_prev   <= '0;
            r_stall_cnt   <= '0;
            r_stalled     <= 1'b0;
            r_hall_period <= CNT_MAX;
        end else begin
            r_hall_meta <= w_hall_raw;
            r_hall_sync <= r_hall_meta;
            r_hall_prev <= r_hall_sync;
            r_stall_cnt <= w_stall_cnt_next;
            // Tracks the counter value it is registered alongside
            r_stalled   <= (w_stall_cnt_next >= STALL_TH);
            if (w_edge) begin
                r_hall_period <= (r_stall_cnt == CNT_MAX) ? CNT_MAX
                                                          : r_stall_cnt + CNT_W'(1);
            end else if (r_stalled) begin
                r_hall_period <= CNT_MAX;
            end
        end
    end

    assign o_hall_code   = r_hall_sync;
    assign o_stalled     = r_stalled;
    assign o_hall_period = r_hall_period;

endmodule

// File: rtl/bldc_drive_sequencer.sv
// Supervisory sequencer for the six-step commutation stage. Owns the
// commutator direction and a global gate enable; makes sure direction
// only changes after the rotor has stopped and a dwell has elapsed,
// and latches a fault on persistent invalid Hall codes.
// Build option: define BLDC_SEQ_BRAKE_EN to drive brake=1 while coasting
// (dynamic braking); otherwise brake is tied 0 and coasting freewheels.
module bldc_drive_sequencer
    import bldc_pkg::*;
#(
    parameter int CNT_W          = DEF_CNT_W,
    parameter int STALL_CYCLES   = DEF_STALL_CYCLES,
    parameter int DWELL_CYCLES   = DEF_DWELL_CYCLES,
    parameter int INVALID_CYCLES = DEF_INVALID_CYCLES
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_run_req,
    input  logic             i_dir_req,
    input  logic             i_clear_fault,
    input  logic             i_halla,
    input  logic             i_hallb,
    input  logic             i_hallc,
    output logic             o_forward,
    output logic             o_gate_en,
    output logic             o_brake,
    output logic             o_fault,
    output logic             o_stalled,
    output logic [CNT_W-1:0] o_hall_period,
    output logic [2:0]       o_state
);

    localparam logic [CNT_W-1:0] DWELL_LAST   = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] INVALID_LAST = CNT_W'(INVALID_CYCLES - 1);

    logic [2:0]       w_hall_code;
    logic             w_stalled;
    logic             w_code_bad;
    logic             w_invalid_trip;
    logic             w_load_fwd;
    seq_state_e       w_state_next;
    seq_state_e       r_state;
    logic             r_forward;
    logic             r_gate_en;
    logic             r_fault;
    logic [CNT_W-1:0] r_dwell_cnt;
    logic [CNT_W-1:0] r_invalid_cnt;

    hall_edge_timer #(
        .CNT_W        (CNT_W),
        .STALL_CYCLES (STALL_CYCLES)
    ) u_hall_edge_timer (
        .clock         (clock),
        .reset         (reset),
        .i_halla       (i_halla),
        .i_hallb       (i_hallb),
        .i_hallc       (i_hallc),
        .o_hall_code   (w_hall_code),
        .o_stalled     (w_stalled),
        .o_hall_period (o_hall_period)
    );

    // Next-state selection; direction is loaded only when entering DWELL
    always_comb begin
        w_code_bad     = hall_code_invalid(w_hall_code);
        w_invalid_trip = (r_state == ST_RUN) && w_code_bad &&
                         (r_invalid_cnt >= INVALID_LAST);
        w_state_next   = r_state;
        w_load_fwd     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_run_req) begin
                    w_state_next = ST_DWELL;
                    w_load_fwd   = 1'b1;
                end
            end
            ST_DWELL: begin
                if (!i_run_req) begin
                    w_state_next = ST_IDLE;
                end else if (r_dwell_cnt == DWELL_LAST) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_invalid_trip) begin
                    w_state_next = ST_FAULT;
                end else if (!i_run_req) begin
                    w_state_next = ST_COAST;
                end else if (i_dir_req != r_forward) begin
                    w_state_next = ST_COAST;
                end
            end
            ST_COAST: begin
                if (i_run_req && (i_dir_req == r_forward) && !w_stalled) begin
                    // Same direction and still spinning: resume without dwell
                    w_state_next = ST_RUN;
                end else if (w_stalled) begin
                    if (i_run_req) begin
                        w_state_next = ST_DWELL;
                        w_load_fwd   = 1'b1;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            ST_FAULT: begin
                if (i_clear_fault && !i_run_req) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State register with outputs registered from the next state so
    // gate_en drops on the very edge the FSM leaves RUN
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_forward     <= 1'b1;
            r_gate_en     <= 1'b0;
            r_fault       <= 1'b0;
            r_dwell_cnt   <= '0;
            r_invalid_cnt <= '0;
        end else begin
            r_state   <= w_state_next;
            r_gate_en <= (w_state_next == ST_RUN);
            r_fault   <= (w_state_next == ST_FAULT);
            if (w_load_fwd) begin
                r_forward <= i_dir_req;
            end
            // Zero on the first DWELL cycle, counting up while dwelling
            r_dwell_cnt <= (r_state == ST_DWELL) ? r_dwell_cnt + CNT_W'(1) : '0;
            if ((r_state == ST_RUN) && w_code_bad) begin
                if (r_invalid_cnt < INVALID_LAST + CNT_W'(1)) begin
                    r_invalid_cnt <= r_invalid_cnt + CNT_W'(1);
                end
            end else begin
                r_invalid_cnt <= '0;
            end
        end
    end

`ifdef BLDC_SEQ_BRAKE_EN
    logic r_brake;

    // Low-side brake request follows COAST exactly, in step with the state
    always_ff @(posedge clock) begin
        if (reset) begin
            r_brake <= 1'b0;
        end else begin
            r_brake <= (w_state_next == ST_COAST);
        end
    end

    assign o_brake = r_brake;
`else
    assign o_brake = 1'b0;
`endif

    assign o_forward = r_forward;
    assign o_gate_en = r_gate_en;
    assign o_fault   = r_fault;
    assign o_stalled = w_stalled;
    assign o_state   = r_state;

endmodule

// File: tb/tb_bldc_drive_sequencer.sv
// Directed bench for bldc_drive_sequencer with small timing constants.
// Halls are stepped from the cycle task so edges fall every 20 clocks.
module tb_bldc_drive_sequencer;

    localparam int CNT_W          = 8;
    localparam int STALL_CYCLES   = 100;
    localparam int DWELL_CYCLES   = 10;
    localparam int INVALID_CYCLES = 5;
`ifdef BLDC_SEQ_BRAKE_EN
    localparam bit BRAKE_ON = 1'b1;
`else
    localparam bit BRAKE_ON = 1'b0;
`endif

    logic             clock = 1'b0;
    logic             reset;
    logic             run_req;
    logic             dir_req;
    logic             clear_fault;
    logic             halla, hallb, hallc;
    logic             forward;
    logic             gate_en;
    logic             brake;
    logic             fault;
    logic             stalled;
    logic [CNT_W-1:0] hall_period;
    logic [2:0]       state;

    int n_vec = 0;
    int n_bad = 0;
    bit hall_auto = 1'b0;
    int hall_phase = 0;

    bldc_drive_sequencer #(
        .CNT_W          (CNT_W),
        .STALL_CYCLES   (STALL_CYCLES),
        .DWELL_CYCLES   (DWELL_CYCLES),
        .INVALID_CYCLES (INVALID_CYCLES)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .i_run_req     (run_req),
        .i_dir_req     (dir_req),
        .i_clear_fault (clear_fault),
        .i_halla       (halla),
        .i_hallb       (hallb),
        .i_hallc       (hallc),
        .o_forward     (forward),
        .o_gate_en     (gate_en),
        .o_brake       (brake),
        .o_fault       (fault),
        .o_stalled     (stalled),
        .o_hall_period (hall_period),
        .o_state       (state)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n clocks; inputs change 1 time unit after each rising edge
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            if (hall_auto) begin
                hall_phase++;
                if (hall_phase == 20) begin
                    hall_phase = 0;
                    hallc = ~hallc;   // alternate 101 / 100
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1; run_req = 1'b0; dir_req = 1'b0; clear_fault = 1'b0;
        halla = 1'b1; hallb = 1'b0; hallc = 1'b1;
        tick(3);
        check("rst_state",   32'(state), 32'd0);
        check("rst_forward", 32'(forward), 32'd1);
        check("rst_gate",    32'(gate_en), 32'd0);
        check("rst_fault",   32'(fault), 32'd0);
        check("rst_brake",   32'(brake), 32'd0);
        check("rst_period",  32'(hall_period), 32'd255);
        check("rst_stalled", 32'(stalled), 32'd0);
        reset = 1'b0;
        tick(2);

        // 1: start reverse, exactly DWELL_CYCLES clocks of dwell
        run_req = 1'b1;
        tick(1);
        check("s1_dwell",     32'(state), 32'd1);
        check("s1_fwd",       32'(forward), 32'd0);
        check("s1_gate_off",  32'(gate_en), 32'd0);
        tick(9);
        check("s1_dwell_end", 32'(state), 32'd1);
        check("s1_gate_late", 32'(gate_en), 32'd0);
        tick(1);
        check("s1_run",       32'(state), 32'd2);
        check("s1_gate_on",   32'(gate_en), 32'd1);

        // 2: period measurement, then stall detection
        hall_auto = 1'b1; hall_phase = 0;
        tick(45);
        check("s2_period20",  32'(hall_period), 32'd20);
        check("s2_not_stall", 32'(stalled), 32'd0);
        hall_auto = 1'b0;
        tick(110);
        check("s2_stalled",   32'(stalled), 32'd1);
        check("s2_period_sat", 32'(hall_period), 32'd255);
        check("s2_still_run", 32'(state), 32'd2);

        // 3: reversal request while spinning
        hall_auto = 1'b1; hall_phase = 0;
        tick(45);
        check("s3_period20",  32'(hall_period), 32'd20);
        dir_req = 1'b1;
        tick(1);
        check("s3_coast",     32'(state), 32'd3);
        check("s3_gate_off",  32'(gate_en), 32'd0);
        check("s3_fwd_keep",  32'(forward), 32'd0);
        check("s3_brake",     32'(brake), 32'(BRAKE_ON));
        tick(30);
        check("s3_coast_hold", 32'(state), 32'd3);
        check("s3_brake_hold", 32'(brake), 32'(BRAKE_ON));
        hall_auto = 1'b0;
        for (int i = 0; i < 200 && state != 3'd1; i++) tick(1);
        check("s3_dwell",     32'(state), 32'd1);
        check("s3_fwd_new",   32'(forward), 32'd1);
        check("s3_brake_off", 32'(brake), 32'd0);
        tick(9);
        check("s3_dwell_end", 32'(gate_en), 32'd0);
        tick(1);
        check("s3_run",       32'(state), 32'd2);
        check("s3_gate_on",   32'(gate_en), 32'd1);

        // 4: brief run_req drop resumes without dwell
        hall_auto = 1'b1; hall_phase = 0;
        tick(25);
        run_req = 1'b0;
        tick(1);
        check("s4_coast",     32'(state), 32'd3);
        check("s4_gate_off",  32'(gate_en), 32'd0);
        tick(10);
        check("s4_coast_hold", 32'(state), 32'd3);
        run_req = 1'b1;
        tick(1);
        check("s4_resume",    32'(state), 32'd2);
        check("s4_gate_on",   32'(gate_en), 32'd1);
        check("s4_fwd_keep",  32'(forward), 32'd1);
        check("s4_brake_off", 32'(brake), 32'd0);

        // 5: invalid Hall code 111 for 4 then 5 clocks
        hall_auto = 1'b0;
        halla = 1'b1; hallb = 1'b1; hallc = 1'b1;
        tick(4);
        halla = 1'b1; hallb = 1'b0; hallc = 1'b1;
        tick(4);
        check("s5_inv4_run",   32'(state), 32'd2);
        check("s5_inv4_fault", 32'(fault), 32'd0);
        halla = 1'b1; hallb = 1'b1; hallc = 1'b1;
        tick(5);
        halla = 1'b1; hallb = 1'b0; hallc = 1'b1;
        tick(1);
        check("s5_inv5_pre",   32'(state), 32'd2);
        tick(1);
        check("s5_fault_state", 32'(state), 32'd4);
        check("s5_fault",       32'(fault), 32'd1);
        check("s5_gate_off",    32'(gate_en), 32'd0);
        clear_fault = 1'b1;
        tick(3);
        check("s5_clear_ignored", 32'(state), 32'd4);
        run_req = 1'b0;
        tick(1);
        check("s5_cleared",    32'(state), 32'd0);
        check("s5_fault_low",  32'(fault), 32'd0);
        clear_fault = 1'b0;

        // 6: reset mid-DWELL and mid-RUN
        dir_req = 1'b0; run_req = 1'b1;
        tick(1);
        check("s6_dwell_fwd",  32'(forward), 32'd0);
        tick(3);
        reset = 1'b1;
        tick(1);
        check("s6_rd_state",   32'(state), 32'd0);
        check("s6_rd_gate",    32'(gate_en), 32'd0);
        check("s6_rd_fwd",     32'(forward), 32'd1);
        reset = 1'b0;
        tick(11);
        check("s6_run",        32'(state), 32'd2);
        check("s6_run_gate",   32'(gate_en), 32'd1);
        reset = 1'b1;
        tick(1);
        check("s6_rr_state",   32'(state), 32'd0);
        check("s6_rr_gate",    32'(gate_en), 32'd0);
        check("s6_rr_fwd",     32'(forward), 32'd1);
        check("s6_rr_period",  32'(hall_period), 32'd255);
        reset = 1'b0; run_req = 1'b0;
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
